// File: rtl/mul_share_pkg.sv
// Shared widths and FSM encoding for the shared-multiplier arbiter.
package mul_share_pkg;

    localparam int unsigned OPW_W  = 4;
    localparam int unsigned PROD_W = 2 * OPW_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mul_share_arb_if.sv
// Requester and response channels of the shared-multiplier arbiter.
interface mul_share_arb_if
    import mul_share_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned OPW = OPW_W,
    parameter int unsigned IDW = 2
);

    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*OPW-1:0]   req_a;
    logic [N*OPW-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*OPW-1:0]   rsp_prod;
    logic [IDW-1:0]     rsp_id;
    logic               busy;

    // Requester/consumer side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_prod, rsp_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_prod, rsp_id, busy
    );

endinterface

// File: rtl/arr_mul.sv
// 4x4 unsigned combinational array multiplier: sum of shifted partial products.
module arr_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] s
);

    // One partial-product row per multiplier bit, shifted into place.
    assign s = {4'b0000, a & {4{b[0]}}}
             + {3'b000,  a & {4{b[1]}}, 1'b0}
             + {2'b00,   a & {4{b[2]}}, 2'b00}
             + {1'b0,    a & {4{b[3]}}, 3'b000};

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter that time-shares one arr_mul among N requesters.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned OPW = OPW_W,
    parameter int unsigned IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    mul_share_arb_if.slave bus
);

    state_e              state_q;
    logic [OPW-1:0]      a_q;
    logic [OPW-1:0]      b_q;
    logic [IDW-1:0]      id_q;
    logic [IDW-1:0]      last_q;
    logic [PROD_W-1:0]   prod_q;
    logic                rsp_valid_q;
    logic                busy_q;

    logic [IDW:0]        pick_c;
    logic                gnt_vld_c;
    logic [IDW-1:0]      gnt_idx_c;
    logic [PROD_W-1:0]   prod_c;

    // Nearest valid index after 'last', wrapping modulo N; MSB flags a hit.
    // Scanning from the farthest candidate down lets the nearest one win.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] valid,
                                             input logic [IDW-1:0] last);
        logic [IDW:0]   pick;
        logic [IDW-1:0] idx;
        pick = '0;
        for (int k = int'(N); k > 0; k--) begin
            idx = IDW'((int'(last) + k) % int'(N));
            if (valid[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    assign pick_c    = rr_pick(bus.req_valid, last_q);
    assign gnt_vld_c = pick_c[IDW];
    assign gnt_idx_c = pick_c[IDW-1:0];

    // Grant is combinational so the requester sees it in the accepting cycle.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && gnt_vld_c) begin
            bus.req_ready[gnt_idx_c] = 1'b1;
        end
    end

    arr_mul u_arr_mul (
        .a (a_q),
        .b (b_q),
        .s (prod_c)
    );

    // Sequencer: accept one operand pair, multiply, hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            last_q      <= IDW'(N - 1);
            prod_q      <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld_c) begin
                        a_q     <= bus.req_a[32'(gnt_idx_c) * OPW +: OPW];
                        b_q     <= bus.req_b[32'(gnt_idx_c) * OPW +: OPW];
                        id_q    <= gnt_idx_c;
                        last_q  <= gnt_idx_c;
                        busy_q  <= 1'b1;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    prod_q      <= prod_c;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_prod  = prod_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one 4x4 unsigned combinational array multiplier (`arr_mul`) among `N` requesters. Each requester offers an operand pair with a valid/ready handshake. The block grants one requester, registers its operands into the multiplier, captures the 8-bit product, and returns it on a single response channel tagged with the requester index. It sits between the requester clients and the shared `arr_mul` instance.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `OPW`, default 4: operand width. Fixed at 4 to match `arr_mul`; the product is `2*OPW` = 8 bits.
- `IDW`, default 2: requester-index width, equal to clog2(`N`).

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  `N`  per-requester operand valid.
- `req_ready`  out  `N`  per-requester accept; at most one bit high.
- `req_a`  in  `N*OPW`  packed multiplicand; requester i uses bits [i*OPW +: OPW].
- `req_b`  in  `N*OPW`  packed multiplier; same packing as `req_a`.
- `rsp_valid`  out  1  response holds a valid product.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_prod`  out  8  registered product a*b.
- `rsp_id`  out  `IDW`  index of the requester that owns the product.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - If any `req_valid` is high, grant the winner g and drive `req_ready[g]` = 1 combinationally in that cycle.
  - On that edge, latch `req_a[g]`, `req_b[g]` into the operand registers, latch g into the id register, then go to MUL.
  - With no requests, stay in IDLE.
- MUL:
  - The operand registers drive `arr_mul`.
  - Capture its 8-bit output into `rsp_prod` and go to RESP.
  - No grants are issued in this state.
- RESP:
  - `rsp_valid` = 1. `rsp_prod` and `rsp_id` hold stable.
  - On `rsp_ready` = 1, go to IDLE. Otherwise stay in RESP indefinitely (backpressure).
- Arbitration:
  - Round-robin over indices. Search starts at `last_grant+1` and wraps modulo `N`.
  - After reset, `last_grant` = `N-1`, so requester 0 has top priority.
  - `last_grant` updates only on an accepted grant.
- Requester rules:
  - Once asserted, `req_valid[i]` and its operands stay stable until `req_ready[i]` is seen.
  - The bench checks this rule; the RTL does not.
- Arithmetic:
  - Unsigned.
  - 15*15 = 225 fits in 8 bits; no overflow handling.

## Timing
- Reset values:
  - FSM = IDLE.
  - `req_ready` = 0 (all bits).
  - `rsp_valid` = 0, `rsp_prod` = 0, `rsp_id` = 0, `busy` = 0.
  - `last_grant` = `N-1`.
- Latency: grant at edge T, then `rsp_valid` rises after edge T+2.
- Throughput: with `rsp_ready` tied high, one product every 3 cycles.
- `req_ready` is combinational from FSM state and `req_valid`. There is no combinational path from `rsp_ready` to `req_ready`.
- Simultaneous requests in IDLE: exactly one grant. Other requests stay pending and are not lost.
- A request arriving during MUL or RESP waits until the next IDLE.
- Reset in any state: the in-flight transaction is dropped and no response is issued. All outputs take their reset values on the next edge.

## Structure
- Shared package `mul_share_pkg` holds:
  - operand width `OPW` = 4 and product width 8;
  - the FSM state enum (IDLE, MUL, RESP).
- One sub-module: `arr_mul` instantiated unchanged, taking `a`, `b` and producing an 8-bit `s`.
- Round-robin pick is a combinational function in the same file, not a separate module.

## Test plan
- Single requester 0 sends a=2, b=3 with `rsp_ready` = 1 -> `rsp_prod` = 00000110, `rsp_id` = 0, `rsp_valid` rises exactly 2 cycles after the `req_ready` cycle.
- Requesters 0..3 send all at once: 10*5, 15*15, 9*7, 2*3 -> responses in id order 0,1,2,3 with products 50, 225, 63, 6.
- Requesters 1 and 2 hold `req_valid` permanently with a=1, b=1 -> grants alternate 1,2,1,2; neither starves.
- Send 15*15 with `rsp_ready` low for 5 cycles -> `rsp_valid` stays 1 and `rsp_prod` = 11100001 stays stable; no `req_ready` pulses; one transfer occurs when `rsp_ready` rises.
- Assert `rst` for 1 cycle while in MUL -> outputs take reset values on the next edge, no response is produced, and the next grant goes to requester 0.
- Exhaustive sweep: requester 3 sends all 256 (a,b) pairs -> every `rsp_prod` equals a*b, with `rsp_id` = 3.
